// File: rtl/id_exe_skid_buffer.sv
// ============================================================================
// id_exe_skid_buffer : 2-entry elastic ID->EXE register with registered ready
// Optional: YSYX_22040125_BUBBLE_CNT_EN adds the bubble_cnt idle counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_exe_skid_buffer #(
  parameter int DW   = 160,
  parameter int CNTW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
`ifdef YSYX_22040125_BUBBLE_CNT_EN
  ,
  output logic [CNTW-1:0] bubble_cnt
`endif
);

  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] main_data_q,  main_data_d;
  logic [DW-1:0] skid_data_q,  skid_data_d;

  logic w_in_fire;
  logic w_out_fire;

  // in_ready comes straight from a flop, so ID never sees a path from out_ready.
  assign in_ready   = ~skid_valid_q;
  assign out_valid  = main_valid_q;
  assign out_data   = main_data_q;

  assign w_in_fire  = in_valid & ~skid_valid_q;
  assign w_out_fire = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (w_in_fire) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
          end
        end
        2'b10: begin
          if (w_in_fire && w_out_fire) begin
            main_data_d  = in_data;
          end else if (w_in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
          end else if (w_out_fire) begin
            main_valid_d = 1'b0;
          end
        end
        2'b11: begin
          if (w_out_fire) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          // Unreachable (skid without main); fall back to EMPTY.
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

`ifdef YSYX_22040125_BUBBLE_CNT_EN
  logic [CNTW-1:0] bubble_cnt_q, bubble_cnt_d;

  // Counts cycles where EXE was willing but had nothing; flush does not clear it.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (out_ready && !main_valid_q && (bubble_cnt_q != {CNTW{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire
